// File: rtl/xcvr_reconfig_readback_checker.sv
// xcvr_reconfig_readback_checker: reads back each DPRIO profile entry over Avalon-MM
// and checks the masked readback byte against the masked expected value.
module xcvr_reconfig_readback_checker #(
  parameter int RAM_DEPTH      = 7,
  parameter int ADDR_WIDTH     = 11,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  mgmt_clk,
  input  logic                  mgmt_reset,
  input  logic                  start,
  output logic [7:0]            tbl_index,
  input  logic [25:0]           tbl_data,
  output logic [ADDR_WIDTH-1:0] reconfig_address,
  output logic                  reconfig_read,
  input  logic [31:0]           reconfig_readdata,
  input  logic                  reconfig_waitrequest,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout_err,
  output logic [3:0]            mismatch_count,
  output logic [7:0]            first_fail_index,
  output logic [7:0]            first_fail_data
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, COMPARE, FINISH} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_tmo;
  logic [7:0] r_idx, r_rd_byte, r_ffi, r_ffd;
  logic [3:0] r_mcnt;
  logic r_pass, r_tmo_err;
  logic w_mismatch, w_last, w_expired, w_unused;
  assign w_unused = ^reconfig_readdata[31:8];
  assign w_mismatch = ((r_rd_byte ^ tbl_data[7:0]) & tbl_data[15:8]) != 8'd0;
  assign w_last = r_idx == 8'(RAM_DEPTH - 1);
  assign w_expired = reconfig_waitrequest && r_tmo == TW'(TIMEOUT_CYCLES - 1);
  assign reconfig_address = reconfig_read ? ADDR_WIDTH'(tbl_data[25:16]) : '0;
  assign tbl_index = r_idx;
  assign pass = r_pass;
  assign timeout_err = r_tmo_err;
  assign mismatch_count = r_mcnt;
  assign first_fail_index = r_ffi;
  assign first_fail_data = r_ffd;
  always_comb begin
    w_next = r_state;
    reconfig_read = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        w_next = start ? ISSUE : IDLE;
      end
      ISSUE: begin
        reconfig_read = 1'b1;
        w_next = !reconfig_waitrequest ? COMPARE : (w_expired ? FINISH : ISSUE);
      end
      COMPARE: w_next = w_last ? FINISH : ISSUE;
      default: begin
        done = 1'b1;
        w_next = IDLE;
      end
    endcase
  end
  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset) begin
      r_state <= IDLE;
      r_tmo <= '0;
      r_idx <= '0;
      r_rd_byte <= '0;
      r_ffi <= '0;
      r_ffd <= '0;
      r_mcnt <= '0;
      r_pass <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start) begin
          r_tmo <= '0;
          r_idx <= '0;
          r_ffi <= '0;
          r_ffd <= '0;
          r_mcnt <= '0;
          r_pass <= 1'b0;
          r_tmo_err <= 1'b0;
        end
        ISSUE: begin
          if (!reconfig_waitrequest) r_rd_byte <= reconfig_readdata[7:0];
          else if (w_expired) r_tmo_err <= 1'b1;
          else r_tmo <= r_tmo + 1'b1;
        end
        COMPARE: begin
          if (w_mismatch) begin
            r_mcnt <= r_mcnt + {3'd0, r_mcnt != 4'hF};
            if (r_mcnt == 4'd0) begin
              r_ffi <= r_idx;
              r_ffd <= r_rd_byte;
            end
          end
          // pass must already include this final compare when done pulses
          if (w_last) r_pass <= !w_mismatch && r_mcnt == 4'd0;
          else begin
            r_idx <= r_idx + 8'd1;
            r_tmo <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_xcvr_reconfig_readback_checker.sv
// tb_xcvr_reconfig_readback_checker: randomized readback runs checked against a table-walk model.
module tb_xcvr_reconfig_readback_checker;
  localparam int DEPTH = 7;
  localparam int TMO = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] tbl_index, first_fail_index, first_fail_data;
  logic [25:0] tbl_data;
  logic [10:0] reconfig_address;
  logic reconfig_read, reconfig_waitrequest, busy, done, pass, timeout_err;
  logic [31:0] reconfig_readdata;
  logic [3:0] mismatch_count;
  logic [25:0] tbl [DEPTH];
  logic [7:0] mem [1024];
  logic [23:0] r_garbage = '0;
  int cyc = 0, scnt = 0, g_stalls = 0, n_chk = 0, n_fail = 0;
  bit stuck_en = 0;
  logic [9:0] stuck_addr = '0;
  always #5 clk = ~clk;
  xcvr_reconfig_readback_checker #(.RAM_DEPTH(DEPTH), .ADDR_WIDTH(11), .TIMEOUT_CYCLES(TMO)) dut (
    .mgmt_clk(clk), .mgmt_reset(rst), .start(start), .tbl_index(tbl_index), .tbl_data(tbl_data),
    .reconfig_address(reconfig_address), .reconfig_read(reconfig_read),
    .reconfig_readdata(reconfig_readdata), .reconfig_waitrequest(reconfig_waitrequest),
    .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err),
    .mismatch_count(mismatch_count), .first_fail_index(first_fail_index),
    .first_fail_data(first_fail_data));
  assign tbl_data = (tbl_index < 8'(DEPTH)) ? tbl[tbl_index[2:0]] : 26'h0;
  assign reconfig_readdata = {r_garbage, mem[reconfig_address[9:0]]};
  assign reconfig_waitrequest = reconfig_read &&
    (stuck_en ? reconfig_address[9:0] == stuck_addr : scnt < g_stalls);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    r_garbage <= 24'($urandom);
    scnt <= (reconfig_read && reconfig_waitrequest) ? scnt + 1 : 0;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic load_cfg1();
    tbl[0] = {10'h132, 8'h04, 8'h04};
    tbl[1] = {10'h134, 8'h30, 8'h10};
    tbl[2] = {10'h135, 8'hFF, 8'h2C};
    tbl[3] = {10'h136, 8'h0F, 8'h0A};
    tbl[4] = {10'h139, 8'h07, 8'h05};
    tbl[5] = {10'h13A, 8'h80, 8'h80};
    tbl[6] = {10'h13B, 8'hFF, 8'h19};
  endtask
  // masked-out bits of every readback byte are random garbage
  task automatic fill_match();
    for (int i = 0; i < DEPTH; i++)
      mem[tbl[i][25:16]] = tbl[i][7:0] ^ (8'($urandom) & ~tbl[i][15:8]);
  endtask
  task automatic run(input int stalls, input int stuck, input bit poke);
    logic [10:0] exp_q[$], got_q[$];
    logic [10:0] prev_a = '0;
    logic [7:0] rb, exp_ffi = '0, exp_ffd = '0;
    int exp_cnt = 0, n_ent, exp_delta, exp_stall, t0, dcyc = -1, stall_tot = 0;
    bit prev_stall = 0;
    g_stalls = stalls;
    stuck_en = stuck >= 0;
    n_ent = stuck_en ? stuck : DEPTH;
    if (stuck_en) stuck_addr = tbl[stuck][25:16];
    for (int i = 0; i < n_ent; i++) begin
      exp_q.push_back({1'b0, tbl[i][25:16]});
      rb = mem[tbl[i][25:16]];
      if (((rb ^ tbl[i][7:0]) & tbl[i][15:8]) != 0) begin
        if (exp_cnt == 0) begin
          exp_ffi = 8'(i);
          exp_ffd = rb;
        end
        if (exp_cnt < 15) exp_cnt++;
      end
    end
    exp_delta = stuck_en ? stuck * (stalls + 2) + TMO : DEPTH * (stalls + 2);
    exp_stall = n_ent * stalls + (stuck_en ? TMO : 0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
    chk("first_read", {31'd0, reconfig_read}, 1);
    for (int n = 0; n < 600 && dcyc < 0; n++) begin
      if (n > 0) @(negedge clk);
      if (poke) start = (n == 5);
      if (reconfig_read) begin
        if (prev_stall && reconfig_address !== prev_a) chk("addr_stable", {21'd0, reconfig_address}, {21'd0, prev_a});
        if (reconfig_waitrequest) stall_tot++;
        else got_q.push_back(reconfig_address);
        prev_stall = reconfig_waitrequest;
        prev_a = reconfig_address;
      end else prev_stall = 0;
      if (done) begin
        dcyc = cyc - t0;
        if (poke) start = 1'b1;
      end
    end
    if (dcyc < 0) chk("done_seen", 0, 1);
    chk("done_lat", dcyc, exp_delta);
    chk("stall_cycles", stall_tot, exp_stall);
    chk("busy_at_done", {31'd0, busy}, 1);
    chk("pass", {31'd0, pass}, {31'd0, exp_cnt == 0 && !stuck_en});
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, stuck_en});
    chk("mismatch_count", {28'd0, mismatch_count}, exp_cnt);
    chk("first_fail_index", {24'd0, first_fail_index}, {24'd0, exp_ffi});
    chk("first_fail_data", {24'd0, first_fail_data}, {24'd0, exp_ffd});
    chk("read_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("read_addr%0d", i), {21'd0, got_q[i]}, {21'd0, exp_q[i]});
    @(negedge clk) start = 1'b0;
    chk("done_one_pulse", {31'd0, done}, 0);
    chk("idle_after", {31'd0, busy}, 0);
    chk("pass_held", {31'd0, pass}, {31'd0, exp_cnt == 0 && !stuck_en});
    stuck_en = 0;
  endtask
  initial begin
    int dones;
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
    load_cfg1();
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_read", {31'd0, reconfig_read}, 0);
    chk("rst_addr", {21'd0, reconfig_address}, 0);
    chk("rst_index", {24'd0, tbl_index}, 0);
    chk("rst_outs", {done, pass, timeout_err, mismatch_count, first_fail_index, first_fail_data}, 0);
    rst = 1'b0;
    @(negedge clk);
    fill_match();
    run(0, -1, 0);
    fill_match();
    mem[10'h13B] = 8'h18;
    mem[10'h136] = 8'hF5;
    run(0, -1, 0);
    fill_match();
    mem[10'h132] = 8'hFB;
    run(0, -1, 0);
    fill_match();
    run(5, -1, 1);
    run(0, 2, 0);
    g_stalls = 5;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    chk("pre_rst_read", {31'd0, reconfig_read}, 1);
    #2 rst = 1'b1;
    #1 chk("async_read_drop", {31'd0, reconfig_read}, 0);
    chk("async_busy_drop", {31'd0, busy}, 0);
    @(negedge clk) rst = 1'b0;
    dones = 0;
    repeat (30) @(negedge clk) if (done || busy) dones++;
    chk("no_done_after_rst", dones, 0);
    fill_match();
    run(0, -1, 0);
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] = 26'($urandom);
        if ($urandom_range(0, 4) == 0) tbl[i][15:8] = 8'h00;
      end
      if (it == 0) tbl[3][25:16] = 10'h3FF;
      fill_match();
      for (int i = 0; i < DEPTH; i++)
        if ($urandom_range(0, 2) == 0) mem[tbl[i][25:16]] = 8'($urandom);
      run($urandom_range(0, 3), -1, it[0]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/xcvr_reconfig_readback_checker.md
Name: xcvr_reconfig_readback_checker

Overview:
- Reads back and verifies a transceiver reconfiguration profile. It is the read-side counterpart of the profile writer that applies DPRIO address/mask/value entries.
- Walks a profile table of 26-bit entries: [25:16] DPRIO address, [15:8] bit mask, [7:0] expected value.
- For each entry, issues one Avalon-MM read on the transceiver reconfig interface and compares the masked readback against the masked expected value.
- Sits beside the reconfig master on the management clock domain. It runs after a rate switch (e.g. the 3.125 Gbps CDR profile) to confirm that the settings landed.

Parameters:
- RAM_DEPTH, 7, number of profile entries to check (1..255).
- ADDR_WIDTH, 11, reconfig_address width; the 10-bit entry address is zero-extended.
- TIMEOUT_CYCLES, 1024, maximum cycles reconfig_read may stall on waitrequest before the run aborts (>=2).

Ports:
- mgmt_clk  in  1  management clock; all logic is on this clock.
- mgmt_reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a check run; ignored while busy.
- tbl_index  out  8  index of the profile entry being checked.
- tbl_data  in  26  profile entry at tbl_index; combinational, valid in the same cycle.
- reconfig_address  out  ADDR_WIDTH  Avalon-MM read address.
- reconfig_read  out  1  Avalon-MM read strobe.
- reconfig_readdata  in  32  read data; valid in the cycle where reconfig_read=1 and reconfig_waitrequest=0. Only bits [7:0] are used.
- reconfig_waitrequest  in  1  Avalon-MM stall.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  high when the last run had zero mismatches and no timeout.
- timeout_err  out  1  high when the last run aborted on waitrequest.
- mismatch_count  out  4  number of mismatching entries; saturates at 15.
- first_fail_index  out  8  index of the first mismatching entry.
- first_fail_data  out  8  raw readback byte of the first mismatching entry.

Behaviour:
- Reset values: all outputs 0; state IDLE; tbl_index=0. Reset during a run drops reconfig_read immediately (asynchronous) and discards the run; done is not pulsed.
- FSM states: IDLE, ISSUE, COMPARE, FINISH.
- IDLE: busy=0. When start=1 at an edge, go to ISSUE and:
  - clear mismatch_count, first_fail_*, pass, timeout_err;
  - set tbl_index=0 and the timeout counter to 0.
- ISSUE:
  - busy=1, reconfig_read=1, reconfig_address={0, tbl_data[25:16]}; address and read are held stable while reconfig_waitrequest=1.
  - When reconfig_waitrequest=0, register rd_byte=reconfig_readdata[7:0] and go to COMPARE.
  - Otherwise the timeout counter increments. If waitrequest is still high after TIMEOUT_CYCLES cycles in ISSUE, drop read, set timeout_err=1, and go to FINISH.
- COMPARE:
  - reconfig_read=0.
  - Mismatch if (rd_byte & mask) != (expected & mask), with mask=tbl_data[15:8] and expected=tbl_data[7:0].
  - On mismatch: mismatch_count increments (saturating at 15). If this is the first mismatch of the run, latch first_fail_index=tbl_index and first_fail_data=rd_byte.
  - If tbl_index==RAM_DEPTH-1, go to FINISH. Otherwise tbl_index++, reset the timeout counter, and go to ISSUE.
- FINISH:
  - done=1 for exactly one cycle; busy=1 in this cycle.
  - pass = (mismatch count including the final COMPARE ==0) && !timeout_err.
  - Go to IDLE.
- Result outputs hold until the next accepted start.
- Latency with waitrequest tied low: start sampled at edge k, first read asserted in cycle k+1, done high in cycle k+1+2*RAM_DEPTH (k+15 for depth 7).
- Exactly one read per entry. Never more than one outstanding read; there is no pipelining of reads.
- A mask of 0x00 always compares equal.
- start while busy is ignored, including start coinciding with done.
- An entry address of 0x3FF is legal; tbl_index never exceeds RAM_DEPTH-1.

Test Plan:
- Default 7-entry CFG1 table (0x132/04/04 … 0x13B/FF/19); responder returns the matching values with waitrequest=0 → 7 reads at addresses 0x132,0x134,0x135,0x136,0x139,0x13A,0x13B; done in cycle k+15; pass=1; mismatch_count=0.
- Readback 0x13B=0x18 (expected 0x19) and 0x136=0xF5 (mask 0x0F, expected 0xA) → mismatch_count=2, first_fail_index=3, first_fail_data=0xF5, pass=0.
- Readback 0x132=0xFB (bit2 clear, expected 1) with all other bytes masked-out garbage → only entry 0 fails; mismatch_count=1, first_fail_index=0.
- Waitrequest held for 5 cycles on every read → address and read stable throughout; done at k+15+35; pass=1.
- TIMEOUT_CYCLES=16, waitrequest stuck high on entry 2 → read drops after 16 stall cycles; timeout_err=1, pass=0, one done pulse.
- Reset asserted mid-ISSUE → reconfig_read=0 asynchronously; after release busy=0, no done pulse; a new start runs cleanly. A second start during a run has no effect on tbl_index sequencing.
